imem_dmem_arbiter: RTL and testbench

- Arbitrates between the core's instruction-fetch port and its data load/store port onto one shared memory bus.
- Generates the `i_ready` and `d_ready` stall handshakes that the core uses to hold PC and register writeback.
- Sits between the core datapath (`pc`, `memRead`, `memWrite`, `memload`) and the memory or bus interface.
- Second-generation block: address/data widths and priority are parametrised, and bus wait states are tolerated.

---
 rtl/imem_dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory bus between the instruction-fetch and load/store ports and
// returns one-cycle ready pulses. Defining ARB_TIMEOUT_EN enables a bus-timeout abort.
module imem_dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DATA_PRIO   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] instr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] memload,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_read,
  output logic              bus_write,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e state_q;
  logic   last_grant_q;
  logic   d_req;
  logic   data_wins;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q;
`else
  assign bus_err = 1'b0;
`endif

  // Round-robin gives the contested grant to the side that did not win last time.
  always_comb begin
    d_req     = d_read | d_write;
    data_wins = 1'b0;
    if (d_req && !i_req) begin
      data_wins = 1'b1;
    end else if (d_req && i_req) begin
      data_wins = (DATA_PRIO != 0) || (last_grant_q == GRANT_I);
    end else begin
      data_wins = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      instr        <= '0;
      memload      <= '0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_read     <= 1'b0;
      bus_write    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      bus_err      <= 1'b0;
      wait_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            if (data_wins) begin
              // A simultaneous read+write is served as a store.
              state_q      <= DBUS;
              last_grant_q <= GRANT_D;
              bus_addr     <= d_addr;
              bus_wdata    <= d_wdata;
              bus_write    <= d_write;
              bus_read     <= ~d_write;
            end else begin
              state_q      <= IBUS;
              last_grant_q <= GRANT_I;
              bus_addr     <= i_addr;
              bus_wdata    <= '0;
              bus_write    <= 1'b0;
              bus_read     <= 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        IBUS, DBUS: begin
          if (bus_ack) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            state_q   <= RESP;
            if (state_q == IBUS) begin
              instr   <= bus_rdata;
              i_ready <= 1'b1;
            end else begin
              if (bus_read) begin
                memload <= bus_rdata;
              end
              d_ready <= 1'b1;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_err   <= 1'b1;
            i_ready   <= (state_q == IBUS);
            d_ready   <= (state_q == DBUS);
            state_q   <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state_q <= IDLE;
`ifdef ARB_TIMEOUT_EN
          bus_err <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: a round-robin and a data-priority instance run in
// lockstep against a transaction-level reference model.
module tb_imem_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] i_req, d_read, d_write, bus_ack;
  logic [1:0] i_ready, d_ready, bus_read, bus_write, bus_err;
  logic [AW-1:0] i_addr [2];
  logic [AW-1:0] d_addr [2];
  logic [AW-1:0] bus_addr [2];
  logic [DW-1:0] d_wdata [2];
  logic [DW-1:0] instr [2];
  logic [DW-1:0] memload [2];
  logic [DW-1:0] bus_wdata [2];
  logic [DW-1:0] bus_rdata [2];

  // instance 0: round-robin, instance 1: data priority
  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIO(g), .TIMEOUT_CYC(255)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ready(i_ready[g]), .instr(instr[g]),
      .d_read(d_read[g]), .d_write(d_write[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ready(d_ready[g]), .memload(memload[g]),
      .bus_addr(bus_addr[g]), .bus_wdata(bus_wdata[g]), .bus_read(bus_read[g]),
      .bus_write(bus_write[g]), .bus_ack(bus_ack[g]), .bus_rdata(bus_rdata[g]),
      .bus_err(bus_err[g])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: one outstanding transaction, its side, and the pending response.
  bit          m_busy [2];
  bit          m_resp [2];
  bit          m_side [2];   // 0 = fetch, 1 = data
  bit          m_last [2];
  bit          m_wr   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_mem [2];

  function automatic void model_step(int k);
    bit want_i, want_d, pick_d;
    if (rst) begin
      m_busy[k] = 0; m_resp[k] = 0; m_side[k] = 0; m_last[k] = 0; m_wr[k] = 0;
      m_addr[k] = '0; m_wdata[k] = '0; m_instr[k] = '0; m_mem[k] = '0;
    end else if (m_resp[k]) begin
      m_resp[k] = 0;
    end else if (m_busy[k]) begin
      if (bus_ack[k]) begin
        m_busy[k] = 0;
        m_resp[k] = 1;
        if (!m_side[k]) m_instr[k] = bus_rdata[k];
        else if (!m_wr[k]) m_mem[k] = bus_rdata[k];
      end
    end else begin
      want_i = i_req[k];
      want_d = d_read[k] | d_write[k];
      if (want_i || want_d) begin
        if (want_i && want_d) pick_d = (k == 1) ? 1'b1 : !m_last[k];
        else pick_d = want_d;
        m_busy[k] = 1;
        m_side[k] = pick_d;
        m_last[k] = pick_d;
        if (pick_d) begin
          m_addr[k] = d_addr[k]; m_wdata[k] = d_wdata[k]; m_wr[k] = d_write[k];
        end else begin
          m_addr[k] = i_addr[k]; m_wr[k] = 0;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic compare(input int k);
    check_eq($sformatf("u%0d_i_ready", k), i_ready[k], m_resp[k] && !m_side[k]);
    check_eq($sformatf("u%0d_d_ready", k), d_ready[k], m_resp[k] && m_side[k]);
    check_eq($sformatf("u%0d_bus_read", k), bus_read[k], m_busy[k] && !m_wr[k]);
    check_eq($sformatf("u%0d_bus_write", k), bus_write[k], m_busy[k] && m_wr[k]);
    check_eq($sformatf("u%0d_bus_addr", k), bus_addr[k], m_addr[k]);
    check_eq($sformatf("u%0d_instr", k), instr[k], m_instr[k]);
    check_eq($sformatf("u%0d_memload", k), memload[k], m_mem[k]);
    check_eq($sformatf("u%0d_bus_err", k), bus_err[k], 32'd0);
    if (m_busy[k] && m_wr[k])
      check_eq($sformatf("u%0d_bus_wdata", k), bus_wdata[k], m_wdata[k]);
  endtask

  // Stimulus controls: bus responder and optional random requesters.
  bit          rand_en = 0;
  bit          stray_en = 0;
  int          fixed_wait = -1;
  bit          fixed_rdata_en = 0;
  logic [31:0] fixed_rdata = '0;
  int          wait_left [2];
  bit          in_xfer [2];
  bit          prev_strobe0 = 0;
  bit          rr_q [$];

  task automatic tick();
    int r;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      compare(k);
      if (k == 0) begin
        if ((bus_read[0] | bus_write[0]) && !prev_strobe0) rr_q.push_back(bus_addr[0] == d_addr[0]);
        prev_strobe0 = bus_read[0] | bus_write[0];
      end
      if (bus_read[k] | bus_write[k]) begin
        if (!in_xfer[k]) begin
          in_xfer[k] = 1;
          wait_left[k] = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
        end
        if (wait_left[k] == 0) begin
          bus_ack[k] = 1'b1;
          bus_rdata[k] = fixed_rdata_en ? fixed_rdata : $urandom;
        end else begin
          bus_ack[k] = 1'b0;
          wait_left[k]--;
        end
      end else begin
        in_xfer[k] = 0;
        bus_ack[k] = stray_en && ($urandom_range(0, 7) == 0);
        bus_rdata[k] = $urandom;
      end
      if (rand_en) begin
        if (i_ready[k]) i_req[k] = 1'b0;
        if (!i_req[k] && $urandom_range(0, 2) == 0) begin
          i_req[k] = 1'b1;
          i_addr[k] = $urandom & 32'hFFFF_FFFC;
        end
        if (d_ready[k]) begin
          d_read[k] = 1'b0;
          d_write[k] = 1'b0;
        end
        if (!(d_read[k] | d_write[k]) && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 9);
          d_read[k] = (r < 5);
          d_write[k] = (r >= 4);   // r == 4 gives the illegal read+write combination
          d_addr[k] = $urandom & 32'hFFFF_FFFC;
          d_wdata[k] = $urandom;
        end
      end
    end
  endtask

  int lat [2];
  int cnt [2];
  logic [31:0] saved [2];
  bit first_d;
  bit first_seen;

  initial begin
    rst = 1'b1;
    i_req = '0; d_read = '0; d_write = '0; bus_ack = '0;
    for (int k = 0; k < 2; k++) begin
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; bus_rdata[k] = '0;
      wait_left[k] = 0; in_xfer[k] = 0;
    end
    @(posedge clk);
    @(posedge clk);
    tick();
    rst = 1'b0;

    // Zero-wait fetch.
    fixed_wait = 0; fixed_rdata_en = 1; fixed_rdata = 32'h3E80_0093;
    tick();
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b1; i_addr[k] = 32'h0000_0004; lat[k] = 0; cnt[k] = 0;
    end
    for (int t = 1; t <= 8; t++) begin
      tick();
      for (int k = 0; k < 2; k++) if (i_ready[k]) begin
        cnt[k]++;
        if (lat[k] == 0) lat[k] = t + 1;
        i_req[k] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("u%0d_fetch_latency", k), lat[k], 32'd3);
      check_eq($sformatf("u%0d_fetch_pulses", k), cnt[k], 32'd1);
      check_eq($sformatf("u%0d_fetch_instr", k), instr[k], 32'h3E80_0093);
    end
    fixed_rdata_en = 0;

    // Store with four wait states.
    fixed_wait = 4;
    for (int k = 0; k < 2; k++) begin
      saved[k] = memload[k]; cnt[k] = 0;
      d_write[k] = 1'b1; d_addr[k] = 32'h100; d_wdata[k] = 32'hDEAD_BEEF;
    end
    for (int t = 0; t < 12; t++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (bus_write[k]) cnt[k]++;
        if (d_ready[k]) d_write[k] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("u%0d_store_wcycles", k), cnt[k], 32'd5);
      check_eq($sformatf("u%0d_store_memload", k), memload[k], saved[k]);
    end

    // Simultaneous fetch and load: the data-priority instance serves the load first.
    fixed_wait = -1; first_seen = 0; first_d = 0;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b1; i_addr[k] = 32'h200; d_read[k] = 1'b1; d_addr[k] = 32'h300;
    end
    for (int t = 0; t < 30; t++) begin
      tick();
      if (!first_seen && (i_ready[1] || d_ready[1])) begin
        first_seen = 1; first_d = d_ready[1];
      end
      for (int k = 0; k < 2; k++) begin
        if (i_ready[k]) i_req[k] = 1'b0;
        if (d_ready[k]) d_read[k] = 1'b0;
      end
    end
    check_eq("u1_prio_first_is_data", first_d, 32'd1);

    // Round-robin with both requests held continuously.
    rr_q.delete();
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b1; i_addr[k] = 32'h40; d_read[k] = 1'b1; d_addr[k] = 32'h80;
    end
    for (int t = 0; t < 30; t++) tick();
    check_eq("u0_rr_grants_ge4", (rr_q.size() >= 4), 32'd1);
    for (int i = 1; i < rr_q.size() && i < 6; i++)
      check_eq($sformatf("u0_rr_alt%0d", i), rr_q[i], !rr_q[i-1]);

    // Randomized traffic with random wait states and stray acks.
    rand_en = 1; stray_en = 1;
    for (int t = 0; t < 2000; t++) tick();

    // Drain, then reset while a load waits for its ack.
    rand_en = 0; stray_en = 0; fixed_wait = 0;
    i_req = '0; d_read = '0; d_write = '0;
    for (int t = 0; t < 10; t++) tick();
    fixed_wait = 50;
    for (int k = 0; k < 2; k++) begin
      d_read[k] = 1'b1; d_addr[k] = 32'h500;
    end
    for (int t = 0; t < 4; t++) tick();
    rst = 1'b1; d_read = '0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("u%0d_rst_bus_read", k), bus_read[k], 32'd0);
      check_eq($sformatf("u%0d_rst_wdata", k), bus_wdata[k], 32'd0);
      check_eq($sformatf("u%0d_rst_memload", k), memload[k], 32'd0);
    end
    bus_ack = 2'b11;
    tick();
    bus_ack = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tick();
      for (int k = 0; k < 2; k++) check_eq($sformatf("u%0d_late_ack_no_ready", k), d_ready[k], 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
